trace_capture: RTL

Event-to-record front end for the trace ring. It accepts fire-and-forget debug events from core/fabric sources, stamps each with a timestamp, sequence number and drop tally, and packs it into a 128-bit record. Records are buffered in a small FIFO and presented on a ready/valid stream that drives `trace_ring`'s `trace_valid`/`trace_ready`/`trace_data` directly. Events are never back-pressured; when the buffer is full they are dropped and counted.

---
 rtl/carbon_trace_pkg.sv | 57 +++++
 rtl/trace_capture_if.sv | 24 ++
 rtl/trace_fifo.sv | 58 +++++
 rtl/trace_capture.sv | 109 ++++++++++
 4 files changed

// File: rtl/carbon_trace_pkg.sv
// Shared trace record definitions: field offsets, packed record type and packer.
// Producers (trace_capture) and consumers (trace_ring) decode with the same view.
package carbon_trace_pkg;

   localparam int TS_LSB      = 0;
   localparam int TS_W        = 32;
   localparam int PC_LSB      = 32;
   localparam int PC_W        = 32;
   localparam int PAYLOAD_LSB = 64;
   localparam int PAYLOAD_W   = 32;
   localparam int KIND_LSB    = 96;
   localparam int KIND_W      = 4;
   localparam int SRC_LSB     = 100;
   localparam int SRC_FLD_W   = 4;
   localparam int SEQ_LSB     = 104;
   localparam int SEQ_W       = 8;
   localparam int DROPS_LSB   = 112;
   localparam int DROPS_W     = 8;
   localparam int MARK_BIT    = 127;
   localparam int REC_BITS    = 128;

   // Declared MSB first, so ts lands in bits [31:0].
   typedef struct packed {
      logic         mark;
      logic [6:0]   zero;
      logic [7:0]   drops;
      logic [7:0]   seq;
      logic [3:0]   src;
      logic [3:0]   kind;
      logic [31:0]  payload;
      logic [31:0]  pc;
      logic [31:0]  ts;
   } trace_rec_t;

   function automatic trace_rec_t trace_pack(
      input logic [31:0] ts,
      input logic [31:0] pc,
      input logic [31:0] payload,
      input logic [3:0]  kind,
      input logic [3:0]  src,
      input logic [7:0]  seq,
      input logic [7:0]  drops
   );
      trace_rec_t rec;
      rec.mark    = 1'b1;
      rec.zero    = 7'd0;
      rec.drops   = drops;
      rec.seq     = seq;
      rec.src     = src;
      rec.kind    = kind;
      rec.payload = payload;
      rec.pc      = pc;
      rec.ts      = ts;
      return rec;
   endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Event strobe inputs and the ready/valid trace record stream of trace_capture.
interface trace_capture_if #(
   parameter int SRC_W = 4,
   parameter int REC_W = 128
);
   logic             ev_valid;
   logic [SRC_W-1:0] ev_src;
   logic [3:0]       ev_kind;
   logic [31:0]      ev_pc;
   logic [31:0]      ev_payload;
   logic             trace_valid;
   logic             trace_ready;
   logic [REC_W-1:0] trace_data;

   modport master (
      input  ev_valid, ev_src, ev_kind, ev_pc, ev_payload, trace_ready,
      output trace_valid, trace_data
   );

   modport slave (
      output ev_valid, ev_src, ev_kind, ev_pc, ev_payload, trace_ready,
      input  trace_valid, trace_data
   );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers (any DEPTH >= 2) that accepts a
// push while full as long as the same cycle pops.
module trace_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             pop_s;
   logic             push_s;

   assign empty  = (count_r == {CNT_W{1'b0}});
   assign full   = (count_r == CNT_W'(DEPTH));
   assign count  = count_r;
   assign dout   = mem_r[rd_ptr_r];
   assign pop_s  = pop && !empty;
   assign push_s = push && (!full || pop_s);

   // Storage, pointers and occupancy; a write at full reuses the slot being popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/trace_capture.sv
// Stamps fire-and-forget debug events into 128-bit trace records, buffers them,
// and counts the events lost while the buffer is full.
module trace_capture
   import carbon_trace_pkg::*;
#(
   parameter int REC_W = 128,
   parameter int DEPTH = 4,
   parameter int SRC_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                clear_drop,
   trace_capture_if.master     tif,
   output logic [15:0]         drop_count,
   output logic                overflow
);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [31:0]      ts_r;
   logic [7:0]       seq_r;
   logic [7:0]       since_r;
   logic [3:0]       src_ext_s;
   trace_rec_t       rec_s;
   logic             ev_fire_s;
   logic             pop_s;
   logic             accept_s;
   logic             drop_s;
   logic             full_s;
   logic             empty_s;
   logic [CNT_W-1:0] count_s;

   // Zero-extend the source ID into the fixed 4-bit record field.
   always_comb begin
      src_ext_s = 4'b0000;
      src_ext_s[SRC_W-1:0] = tif.ev_src;
   end

   assign rec_s     = trace_pack(ts_r, tif.ev_pc, tif.ev_payload, tif.ev_kind,
                                 src_ext_s, seq_r, since_r);
   assign ev_fire_s = tif.ev_valid && enable;
   assign pop_s     = !empty_s && tif.trace_ready;
   assign accept_s  = ev_fire_s && ((count_s < CNT_W'(DEPTH)) || pop_s);
   assign drop_s    = ev_fire_s && full_s && !pop_s;

   assign tif.trace_valid = !empty_s;

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept_s),
      .din   (rec_s),
      .pop   (pop_s),
      .dout  (tif.trace_data),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   // Free-running timestamp, independent of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_r <= 32'd0;
      end else begin
         ts_r <= ts_r + 32'd1;
      end
   end

   // Sequence number advances per accepted record; drops_since saturates between records.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_r   <= 8'd0;
         since_r <= 8'd0;
      end else if (accept_s) begin
         seq_r   <= seq_r + 8'd1;
         since_r <= 8'd0;
      end else if (drop_s && (since_r != 8'hFF)) begin
         since_r <= since_r + 8'd1;
      end else begin
         since_r <= since_r;
      end
   end

   // Global drop tally; a drop coinciding with clear_drop restarts the count at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= 16'd0;
         overflow   <= 1'b0;
      end else if (drop_s) begin
         overflow <= 1'b1;
         if (clear_drop) begin
            drop_count <= 16'd1;
         end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end else begin
            drop_count <= drop_count;
         end
      end else if (clear_drop) begin
         drop_count <= 16'd0;
         overflow   <= 1'b0;
      end else begin
         drop_count <= drop_count;
         overflow   <= overflow;
      end
   end
endmodule
